// File: rtl/riscv_pipe_pkg.sv
// Shared pipeline definitions: control-bundle bit positions, ALU op encodings, ID/EX FSM states.
package riscv_pipe_pkg;

   localparam int CTRL_W          = 11;
   localparam int CTRL_MUL        = 10;
   localparam int CTRL_JAL        = 9;
   localparam int CTRL_BRANCH     = 8;
   localparam int CTRL_MEM_TO_REG = 7;
   localparam int CTRL_MEM_READ   = 6;
   localparam int CTRL_MEM_WRITE  = 5;
   localparam int CTRL_ALU_SRC    = 4;
   localparam int CTRL_REG_WRITE  = 3;
   localparam int CTRL_ALU_OP_HI  = 2;
   localparam int CTRL_ALU_OP_LO  = 0;

   typedef enum logic [2:0] {
      ALU_R, ALU_I_LOGIC, ALU_LOAD, ALU_STORE, ALU_BRANCH, ALU_LUI, ALU_JAL, ALU_JALR
   } alu_op_e;

   typedef enum logic {IDLE, MUL_BUSY} id_ex_state_t;

   // Counter must be at least one bit wide even when multiplies are single-cycle.
   function automatic int unsigned mul_cnt_width(input int unsigned latency);
      return (latency > 1) ? $clog2(latency) : 1;
   endfunction

endpackage

// File: rtl/id_ex_hazard_detect.sv
// Combinational load-use hazard compare between the load in EX and the sources in ID.
module id_ex_hazard_detect #(
   parameter int unsigned REG_ADDR_W = 5
) (
   input  logic                  ex_valid_i,
   input  logic                  ex_mem_read_i,
   input  logic [REG_ADDR_W-1:0] ex_rd_addr_i,
   input  logic                  id_valid_i,
   input  logic [REG_ADDR_W-1:0] rs1_addr_i,
   input  logic [REG_ADDR_W-1:0] rs2_addr_i,
   output logic                  load_use_o
);

   always_comb begin
      load_use_o = ex_valid_i & ex_mem_read_i & (ex_rd_addr_i != '0) & id_valid_i
                   & ((ex_rd_addr_i == rs1_addr_i) | (ex_rd_addr_i == rs2_addr_i));
   end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion and multi-cycle multiply hold.
// Optional bubble counter output enabled by defining ID_EX_BUBBLE_CNT_EN.
module id_ex_stage
   import riscv_pipe_pkg::*;
#(
   parameter int unsigned DATA_WIDTH  = 32,
   parameter int unsigned REG_ADDR_W  = 5,
   parameter int unsigned MUL_LATENCY = 3
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [CTRL_W-1:0]     ctrl_i,
   input  logic                  id_valid_i,
   input  logic [DATA_WIDTH-1:0] pc_i,
   input  logic [DATA_WIDTH-1:0] rs1_data_i,
   input  logic [DATA_WIDTH-1:0] rs2_data_i,
   input  logic [DATA_WIDTH-1:0] imm_i,
   input  logic [REG_ADDR_W-1:0] rs1_addr_i,
   input  logic [REG_ADDR_W-1:0] rs2_addr_i,
   input  logic [REG_ADDR_W-1:0] rd_addr_i,
   input  logic [3:0]            funct_i,
   input  logic                  flush_i,
   output logic [CTRL_W-1:0]     ex_ctrl_o,
   output logic                  ex_valid_o,
   output logic [DATA_WIDTH-1:0] ex_pc_o,
   output logic [DATA_WIDTH-1:0] ex_rs1_data_o,
   output logic [DATA_WIDTH-1:0] ex_rs2_data_o,
   output logic [DATA_WIDTH-1:0] ex_imm_o,
   output logic [REG_ADDR_W-1:0] ex_rs1_addr_o,
   output logic [REG_ADDR_W-1:0] ex_rs2_addr_o,
   output logic [REG_ADDR_W-1:0] ex_rd_addr_o,
   output logic [3:0]            ex_funct_o,
   output logic                  stall_o
`ifdef ID_EX_BUBBLE_CNT_EN
   ,
   output logic [31:0]           bubble_cnt_o
`endif
);

   localparam int unsigned CNT_W     = mul_cnt_width(MUL_LATENCY);
   localparam bit          MUL_MULTI = (MUL_LATENCY > 1);

   typedef struct packed {
      logic [CTRL_W-1:0]     ctrl;
      logic                  valid;
      logic [DATA_WIDTH-1:0] pc;
      logic [DATA_WIDTH-1:0] rs1_data;
      logic [DATA_WIDTH-1:0] rs2_data;
      logic [DATA_WIDTH-1:0] imm;
      logic [REG_ADDR_W-1:0] rs1_addr;
      logic [REG_ADDR_W-1:0] rs2_addr;
      logic [REG_ADDR_W-1:0] rd_addr;
      logic [3:0]            funct;
   } ex_t;

   ex_t          ex_q, ex_d, id_fields;
   id_ex_state_t state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic         load_use;
   logic         busy;

   id_ex_hazard_detect #(
      .REG_ADDR_W (REG_ADDR_W)
   ) u_hazard (
      .ex_valid_i    (ex_q.valid),
      .ex_mem_read_i (ex_q.ctrl[CTRL_MEM_READ]),
      .ex_rd_addr_i  (ex_q.rd_addr),
      .id_valid_i    (id_valid_i),
      .rs1_addr_i    (rs1_addr_i),
      .rs2_addr_i    (rs2_addr_i),
      .load_use_o    (load_use)
   );

   assign busy    = (state_q == MUL_BUSY);
   assign stall_o = ~flush_i & (busy | load_use);

   always_comb begin
      id_fields          = '{ctrl: ctrl_i, valid: id_valid_i, pc: pc_i, rs1_data: rs1_data_i,
                             rs2_data: rs2_data_i, imm: imm_i, rs1_addr: rs1_addr_i,
                             rs2_addr: rs2_addr_i, rd_addr: rd_addr_i, funct: funct_i};
      // Invalid slots travel with their data but can never have side effects.
      if (!id_valid_i) id_fields.ctrl = '0;

      ex_d    = ex_q;
      state_d = state_q;
      cnt_d   = cnt_q;
      if (flush_i) begin
         ex_d    = '0;
         state_d = IDLE;
         cnt_d   = '0;
      end else if (busy) begin
         cnt_d = cnt_q - CNT_W'(1);
         if (cnt_q == CNT_W'(1)) state_d = IDLE;
      end else if (load_use) begin
         ex_d = '0;
      end else begin
         ex_d = id_fields;
         if (MUL_MULTI && id_valid_i && ctrl_i[CTRL_MUL]) begin
            state_d = MUL_BUSY;
            cnt_d   = CNT_W'(MUL_LATENCY - 1);
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ex_q    <= '0;
         state_q <= IDLE;
         cnt_q   <= '0;
      end else begin
         ex_q    <= ex_d;
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

`ifdef ID_EX_BUBBLE_CNT_EN
   logic [31:0] bubble_cnt_q, bubble_cnt_d;
   logic        bubble_evt;

   always_comb begin
      bubble_evt   = flush_i | (~busy & load_use);
      bubble_cnt_d = bubble_cnt_q;
      if (bubble_evt && (bubble_cnt_q != 32'hFFFF_FFFF)) bubble_cnt_d = bubble_cnt_q + 32'd1;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) bubble_cnt_q <= '0;
      else        bubble_cnt_q <= bubble_cnt_d;
   end

   assign bubble_cnt_o = bubble_cnt_q;
`endif

   assign ex_ctrl_o     = ex_q.ctrl;
   assign ex_valid_o    = ex_q.valid;
   assign ex_pc_o       = ex_q.pc;
   assign ex_rs1_data_o = ex_q.rs1_data;
   assign ex_rs2_data_o = ex_q.rs2_data;
   assign ex_imm_o      = ex_q.imm;
   assign ex_rs1_addr_o = ex_q.rs1_addr;
   assign ex_rs2_addr_o = ex_q.rs2_addr;
   assign ex_rd_addr_o  = ex_q.rd_addr;
   assign ex_funct_o    = ex_q.funct;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed and randomized bench for id_ex_stage against a cycle-level reference model.
module tb_id_ex_stage;
   import riscv_pipe_pkg::*;

   localparam int DW = 32;
   localparam int RAW = 5;
   localparam int ML = 3;

   localparam logic [10:0] C_LW  = 11'h0DA;
   localparam logic [10:0] C_ADD = 11'h008;
   localparam logic [10:0] C_MUL = 11'h408;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   logic [10:0]    ctrl;
   logic           id_valid, flush;
   logic [DW-1:0]  pc, rs1_data, rs2_data, imm;
   logic [RAW-1:0] rs1_addr, rs2_addr, rd_addr;
   logic [3:0]     funct;

   logic [10:0]    ex_ctrl;
   logic           ex_valid, stall;
   logic [DW-1:0]  ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
   logic [RAW-1:0] ex_rs1_addr, ex_rs2_addr, ex_rd_addr;
   logic [3:0]     ex_funct;
   logic [31:0]    bubble_cnt;

   id_ex_stage #(.DATA_WIDTH(DW), .REG_ADDR_W(RAW), .MUL_LATENCY(ML)) dut (
      .clk(clk), .reset(reset), .ctrl_i(ctrl), .id_valid_i(id_valid), .pc_i(pc),
      .rs1_data_i(rs1_data), .rs2_data_i(rs2_data), .imm_i(imm), .rs1_addr_i(rs1_addr),
      .rs2_addr_i(rs2_addr), .rd_addr_i(rd_addr), .funct_i(funct), .flush_i(flush),
      .ex_ctrl_o(ex_ctrl), .ex_valid_o(ex_valid), .ex_pc_o(ex_pc),
      .ex_rs1_data_o(ex_rs1_data), .ex_rs2_data_o(ex_rs2_data), .ex_imm_o(ex_imm),
      .ex_rs1_addr_o(ex_rs1_addr), .ex_rs2_addr_o(ex_rs2_addr), .ex_rd_addr_o(ex_rd_addr),
      .ex_funct_o(ex_funct), .stall_o(stall)
`ifdef ID_EX_BUBBLE_CNT_EN
      , .bubble_cnt_o(bubble_cnt)
`endif
   );

`ifndef ID_EX_BUBBLE_CNT_EN
   assign bubble_cnt = '0;
`endif

   typedef struct packed {
      logic [10:0]    ctrl;
      logic           valid;
      logic [DW-1:0]  pc, rs1d, rs2d, imm;
      logic [RAW-1:0] rs1a, rs2a, rda;
      logic [3:0]     funct;
   } ex_t;

   ex_t         m_ex, m_next;
   int          m_mul_left, m_next_left;
   logic [31:0] m_bcnt, m_next_bcnt;
   logic        m_stall, last_stall;
   int          checks = 0;
   int          failures = 0;

   task automatic check(input string tag, input logic [191:0] obs, input logic [191:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic ex_t dut_ex();
      return {ex_ctrl, ex_valid, ex_pc, ex_rs1_data, ex_rs2_data, ex_imm,
              ex_rs1_addr, ex_rs2_addr, ex_rd_addr, ex_funct};
   endfunction

   // Model: what sits in EX, and how many more cycles a resident multiply must stay.
   task automatic model_eval();
      bit lu;
      ex_t id;
      lu = m_ex.valid && m_ex.ctrl[CTRL_MEM_READ] && (m_ex.rda != 0) && id_valid
           && (m_ex.rda == rs1_addr || m_ex.rda == rs2_addr);
      m_stall     = !flush && (m_mul_left > 0 || lu);
      m_next_bcnt = m_bcnt;
      id = {id_valid ? ctrl : 11'h0, id_valid, pc, rs1_data, rs2_data, imm,
            rs1_addr, rs2_addr, rd_addr, funct};
      if (flush) begin
         m_next = '0; m_next_left = 0;
         if (m_bcnt != 32'hFFFF_FFFF) m_next_bcnt = m_bcnt + 1;
      end else if (m_mul_left > 0) begin
         m_next = m_ex; m_next_left = m_mul_left - 1;
      end else if (lu) begin
         m_next = '0; m_next_left = 0;
         if (m_bcnt != 32'hFFFF_FFFF) m_next_bcnt = m_bcnt + 1;
      end else begin
         m_next = id;
         m_next_left = (id_valid && ctrl[CTRL_MUL]) ? ML - 1 : 0;
      end
   endtask

   task automatic set_id(input logic [10:0] c, input logic v, input logic [RAW-1:0] r1,
                         input logic [RAW-1:0] r2, input logic [RAW-1:0] rd, input logic fl);
      ctrl = c; id_valid = v; rs1_addr = r1; rs2_addr = r2; rd_addr = rd; flush = fl;
      pc = $urandom; rs1_data = $urandom; rs2_data = $urandom; imm = $urandom;
      funct = 4'($urandom);
   endtask

   task automatic cycle(input bit do_rst);
      @(negedge clk);
      if (do_rst) begin
         reset = 1'b0;
         #1;
         m_ex = '0; m_mul_left = 0; m_bcnt = '0;
         check("async_reset_ex", 192'(dut_ex()), 192'(0));
         check("async_reset_stall", 192'(stall), 192'(0));
         #1 reset = 1'b1;
      end
      #1;
      model_eval();
      last_stall = stall;
      check("stall", 192'(stall), 192'(m_stall));
      @(posedge clk);
      #1;
      m_ex = m_next; m_mul_left = m_next_left; m_bcnt = m_next_bcnt;
      check("ex_regs", 192'(dut_ex()), 192'(m_ex));
`ifdef ID_EX_BUBBLE_CNT_EN
      check("bubble_cnt", 192'(bubble_cnt), 192'(m_bcnt));
`endif
   endtask

   initial begin
      reset = 1'b0;
      set_id(C_ADD, 1'b0, 0, 0, 0, 1'b0);
      m_ex = '0; m_mul_left = 0; m_bcnt = '0;
      #12;
      check("reset_ex", 192'(dut_ex()), 192'(0));
      check("reset_stall", 192'(stall), 192'(0));
      check("reset_bcnt", 192'(bubble_cnt), 192'(0));
      reset = 1'b1;

      // Load-use: lw x5 then add x6,x5,x1
      set_id(C_LW, 1'b1, 0, 0, 5, 1'b0);   cycle(0);
      set_id(C_ADD, 1'b1, 5, 1, 6, 1'b0);  cycle(0);
      check("t1_stall", 192'(last_stall), 192'(1));
      check("t1_bubble", 192'({ex_valid, ex_ctrl}), 192'(0));
      cycle(0);
      check("t1_add_rd", 192'(ex_rd_addr), 192'(6));

      // Load to x0 never stalls
      set_id(C_LW, 1'b1, 0, 0, 0, 1'b0);   cycle(0);
      set_id(C_ADD, 1'b1, 0, 1, 6, 1'b0);  cycle(0);
      check("t2_no_stall", 192'(last_stall), 192'(0));
      check("t2_add_rd", 192'(ex_rd_addr), 192'(6));

      // Multiply held for three EX cycles, then add
      set_id(C_MUL, 1'b1, 1, 2, 7, 1'b0);  cycle(0);
      set_id(C_ADD, 1'b1, 3, 4, 8, 1'b0);
      for (int i = 0; i < 2; i++) begin
         cycle(0);
         check("t3_stall", 192'(last_stall), 192'(1));
         check("t3_mul_held", 192'(ex_ctrl[CTRL_MUL]), 192'(1));
      end
      cycle(0);
      check("t3_release", 192'(last_stall), 192'(0));
      check("t3_add_rd", 192'(ex_rd_addr), 192'(8));

      // Flush during load-use stall
      set_id(C_LW, 1'b1, 0, 0, 5, 1'b0);   cycle(0);
      set_id(C_ADD, 1'b1, 5, 1, 6, 1'b1);  cycle(0);
      check("t4_no_stall", 192'(last_stall), 192'(0));
      check("t4_bubble", 192'(ex_valid), 192'(0));

      // Back-to-back multiplies, then reset while cnt == 1
      set_id(C_MUL, 1'b1, 1, 2, 7, 1'b0);
      for (int i = 0; i < 6; i++) cycle(0);
      set_id(C_MUL, 1'b1, 1, 2, 9, 1'b0);  cycle(0);
      cycle(0);
      set_id(C_ADD, 1'b1, 3, 4, 10, 1'b0); cycle(1);
      check("t6_after_reset_rd", 192'(ex_rd_addr), 192'(10));

      for (int n = 0; n < 3000; n++) begin
         logic [10:0] c;
         c = 11'($urandom);
         if ($urandom_range(0, 4) != 0) c[CTRL_MUL] = 1'b0;
         set_id(c, $urandom_range(0, 7) != 0, 5'($urandom_range(0, 7)),
                5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), $urandom_range(0, 11) == 0);
         cycle($urandom_range(0, 59) == 0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
